// File: rtl/stream_sched.sv
// stream_sched: places the fibonacci and timer producers onto one buffer write port.
// It controls the producer enables, holds on backpressure, keeps a 1-entry skid and drains at end of run.
module stream_sched #(
    parameter int DW            = 16,
    parameter int CNT_W         = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_f,
    input  logic             i_start_t,
    input  logic             i_stop,
    input  logic             i_f_valid,
    input  logic [DW-1:0]    i_f_data,
    input  logic             i_t_valid,
    input  logic [DW-1:0]    i_t_data,
    input  logic             i_buffer_full,
    input  logic             i_buffer_empty,
    input  logic             i_data_2_valid,
    output logic             o_f_en,
    output logic             o_t_en,
    output logic [1:0]       o_modulo,
    output logic             o_wr_en,
    output logic [DW-1:0]    o_wr_data,
    output logic             o_wr_parity,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic [7:0]       o_drop_cnt,
    output logic             o_timeout
);

    localparam int TW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_F,
        S_RUN_T,
        S_HOLD_F,
        S_HOLD_T,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_src_f;
    logic             r_skid_v;
    logic [DW-1:0]    r_skid_d;
    logic [CNT_W-1:0] r_word_cnt;
    logic [7:0]       r_drop_cnt;
    logic             r_timeout;
    logic [TW-1:0]    r_drain_cnt;

    logic             w_cap;
    logic             w_src_f;
    logic             w_act_v;
    logic [DW-1:0]    w_act_d;
    logic             w_wr_en;
    logic             w_load;
    logic             w_drop;
    logic             w_in_drain;
    logic             w_drain_done;
    logic             w_drain_to;
    logic             w_run_entry;

    assign w_in_drain   = (r_state == S_DRAIN);
    assign w_drain_done = w_in_drain & ~r_skid_v & i_buffer_empty
                          & ~i_data_2_valid;
    assign w_drain_to   = w_in_drain & ~w_drain_done
                          & (r_drain_cnt == TMAX);
    assign w_run_entry  = (r_state == S_IDLE) & (i_start_f ^ i_start_t);

    assign w_wr_en = r_skid_v & ~i_buffer_full;
    assign w_act_v = w_cap & (w_src_f ? i_f_valid : i_t_valid);
    assign w_act_d = w_src_f ? i_f_data : i_t_data;
    assign w_load  = w_act_v & (~r_skid_v | w_wr_en);
    assign w_drop  = w_act_v & r_skid_v & ~w_wr_en;

    // Pick the capturing source; drain keeps listening to the last run's source.
    always_comb begin
        w_cap   = 1'b1;
        w_src_f = r_src_f;
        unique case (r_state)
            S_RUN_F, S_HOLD_F: w_src_f = 1'b1;
            S_RUN_T, S_HOLD_T: w_src_f = 1'b0;
            S_DRAIN:           w_src_f = r_src_f;
            default:           w_cap   = 1'b0;
        endcase
    end

    // Next-state logic plus Moore enables and modulo from the registered state.
    always_comb begin
        w_next   = r_state;
        o_f_en   = 1'b0;
        o_t_en   = 1'b0;
        o_modulo = 2'b00;
        unique case (r_state)
            S_IDLE: begin
                if (i_start_f & ~i_start_t) begin
                    w_next = S_RUN_F;
                end else if (i_start_t & ~i_start_f) begin
                    w_next = S_RUN_T;
                end
            end
            S_RUN_F: begin
                o_f_en   = 1'b1;
                o_modulo = 2'b10;
                if (i_stop) begin
                    w_next = S_DRAIN;
                end else if (i_buffer_full) begin
                    w_next = S_HOLD_F;
                end
            end
            S_RUN_T: begin
                o_t_en   = 1'b1;
                o_modulo = 2'b01;
                if (i_stop) begin
                    w_next = S_DRAIN;
                end else if (i_buffer_full) begin
                    w_next = S_HOLD_T;
                end
            end
            S_HOLD_F: begin
                o_modulo = 2'b10;
                if (i_stop) begin
                    w_next = S_DRAIN;
                end else if (!i_buffer_full) begin
                    w_next = S_RUN_F;
                end
            end
            S_HOLD_T: begin
                o_modulo = 2'b01;
                if (i_stop) begin
                    w_next = S_DRAIN;
                end else if (!i_buffer_full) begin
                    w_next = S_RUN_T;
                end
            end
            S_DRAIN: begin
                if (w_drain_done || w_drain_to) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Remember which producer the current run belongs to, for the drain phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src_f <= 1'b0;
        end else if (w_run_entry) begin
            r_src_f <= i_start_f;
        end
    end

    // Skid entry: a write frees it, a same-edge arrival reloads it, timeout discards it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_skid_v <= 1'b0;
            r_skid_d <= '0;
        end else if (w_drain_to) begin
            r_skid_v <= 1'b0;
        end else if (w_load) begin
            r_skid_v <= 1'b1;
            r_skid_d <= w_act_d;
        end else if (w_wr_en) begin
            r_skid_v <= 1'b0;
        end
    end

    // Cycles spent in drain; restarts from zero each time drain is entered.
    always_ff @(posedge i_clk) begin
        if (i_rst || !w_in_drain) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + TW'(1);
        end
    end

    // Per-run saturating word and drop counters.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_run_entry) begin
            r_word_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr_en && !(&r_word_cnt)) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Sticky flag: did the last drain end by timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_run_entry) begin
            r_timeout <= 1'b0;
        end else if (w_drain_to) begin
            r_timeout <= 1'b1;
        end
    end

    assign o_wr_en     = w_wr_en;
    assign o_wr_data   = r_skid_d;
    assign o_wr_parity = ^r_skid_d;
    assign o_busy      = (r_state != S_IDLE);
    assign o_word_cnt  = r_word_cnt;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_stream_sched.sv
// tb_stream_sched: randomized and directed stimulus for stream_sched.
// A behavioural model feeds a write scoreboard and a set of status expectations.
module tb_stream_sched;

    localparam int TO = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start_f = 1'b0, start_t = 1'b0, stop = 1'b0;
    logic        f_valid = 1'b0, t_valid = 1'b0;
    logic [15:0] f_data = '0, t_data = '0;
    logic        full = 1'b0, empty = 1'b1, d2v = 1'b0;

    logic        f_en, t_en, wr_en, wr_parity, busy, timeout;
    logic [1:0]  modulo;
    logic [15:0] wr_data, word_cnt;
    logic [7:0]  drop_cnt;

    stream_sched #(.DW(16), .CNT_W(16), .DRAIN_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_start_f(start_f), .i_start_t(start_t), .i_stop(stop),
        .i_f_valid(f_valid), .i_f_data(f_data),
        .i_t_valid(t_valid), .i_t_data(t_data),
        .i_buffer_full(full), .i_buffer_empty(empty),
        .i_data_2_valid(d2v),
        .o_f_en(f_en), .o_t_en(t_en), .o_modulo(modulo),
        .o_wr_en(wr_en), .o_wr_data(wr_data), .o_wr_parity(wr_parity),
        .o_busy(busy), .o_word_cnt(word_cnt), .o_drop_cnt(drop_cnt),
        .o_timeout(timeout)
    );

    // next-cycle stimulus
    logic        n_rst = 1'b1, n_sf = 1'b0, n_st = 1'b0, n_stop = 1'b0;
    logic        n_fv = 1'b0, n_tv = 1'b0, n_full = 1'b0;
    logic        n_empty = 1'b1, n_d2v = 1'b0;
    logic [15:0] n_fd = '0, n_td = '0;

    // model: mode 0 idle, 1 fib run, 2 timer run, 3 drain
    int          m_mode, m_src, m_wc, m_dc, m_dt;
    bit          m_hold, m_sk_v, m_to;
    logic [15:0] m_sk_d;

    int          checks = 0, errors = 0;
    logic [15:0] sb[$];
    bit          mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_src = 0; m_wc = 0; m_dc = 0; m_dt = 0;
        m_hold = 0; m_sk_v = 0; m_to = 0; m_sk_d = '0;
    endfunction

    function automatic void model_update();
        bit          av, wr, done, tox;
        int          s;
        logic [15:0] ad;
        if (rst) begin
            model_reset();
            return;
        end
        av = 0; ad = '0;
        if (m_mode != 0) begin
            s = (m_mode == 3) ? m_src : m_mode;
            if (s == 1) begin av = f_valid; ad = f_data; end
            else begin av = t_valid; ad = t_data; end
        end
        wr   = m_sk_v && !full;
        done = (m_mode == 3) && !m_sk_v && empty && !d2v;
        tox  = (m_mode == 3) && !done && (m_dt == TO - 1);
        if (wr && m_wc < 65535) m_wc++;
        if (av && m_sk_v && !wr && m_dc < 255) m_dc++;
        if (tox) m_sk_v = 0;
        else if (av && (!m_sk_v || wr)) begin m_sk_v = 1; m_sk_d = ad; end
        else if (wr) m_sk_v = 0;
        case (m_mode)
            0: if (start_f != start_t) begin
                m_mode = start_f ? 1 : 2; m_src = m_mode; m_hold = 0;
                m_wc = 0; m_dc = 0; m_to = 0;
            end
            1, 2: if (stop) begin m_mode = 3; m_dt = 0; end
                  else m_hold = full;
            default: if (done) m_mode = 0;
                     else if (tox) begin m_mode = 0; m_to = 1; end
                     else m_dt++;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        rst = n_rst; start_f = n_sf; start_t = n_st; stop = n_stop;
        f_valid = n_fv; f_data = n_fd; t_valid = n_tv; t_data = n_td;
        full = n_full; empty = n_empty; d2v = n_d2v;
        n_rst = 0; n_sf = 0; n_st = 0; n_stop = 0;
        if (m_sk_v && !full) sb.push_back(m_sk_d);
    endtask

    // monitor: status against model, writes against scoreboard
    always @(negedge clk) begin
        logic [15:0] d;
        if (mon_en) begin
            chk("wr_en", wr_en, m_sk_v && !full);
            chk("f_en", f_en, m_mode == 1 && !m_hold);
            chk("t_en", t_en, m_mode == 2 && !m_hold);
            chk("modulo", modulo, m_mode == 1 ? 2 : (m_mode == 2 ? 1 : 0));
            chk("busy", busy, m_mode != 0);
            chk("word_cnt", word_cnt, m_wc);
            chk("drop_cnt", drop_cnt, m_dc);
            chk("timeout", timeout, m_to);
            if (wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_data: got write %h, expected none",
                             wr_data);
                end else begin
                    d = sb.pop_front();
                    chk("wr_data", wr_data, d);
                    chk("wr_parity", wr_parity, $countones(d) % 2);
                end
            end
        end
    end

    initial begin
        logic [15:0] first;
        int drained;
        model_reset();
        cyc();
        mon_en = 1;
        cyc();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_modulo", modulo, 0);
        chk("rst_word_cnt", word_cnt, 0);

        // fib run, valid 1 in 3
        n_sf = 1; cyc();
        for (int i = 0; i < 30; i++) begin
            n_fv = (i % 3 == 0); n_fd = 16'($urandom); cyc();
        end
        n_fv = 0; cyc();
        @(negedge clk);
        chk("t1_word_cnt", word_cnt, 10);
        chk("t1_drop_cnt", drop_cnt, 0);
        chk("t1_f_en", f_en, 1);
        chk("t1_modulo", modulo, 2'b10);

        // drain waits for buffer_empty
        n_stop = 1; n_empty = 0; cyc(); cyc(); cyc();
        @(negedge clk);
        chk("t4_in_drain", busy, 1);
        n_empty = 1; cyc(); cyc();
        @(negedge clk);
        chk("t4_idle", busy, 0);
        chk("t4_timeout", timeout, 0);

        // timer run under backpressure
        n_st = 1; cyc();
        n_full = 1; n_tv = 1;
        for (int i = 0; i < 8; i++) begin
            n_td = 16'($urandom);
            if (i == 0) first = n_td;
            cyc();
        end
        n_tv = 0; cyc();
        @(negedge clk);
        chk("t2_drop_cnt", drop_cnt, 7);
        chk("t2_t_en", t_en, 0);
        chk("t2_wr_en", wr_en, 0);
        chk("t2_skid", wr_data, first);
        n_full = 0; cyc(); cyc();
        n_full = 1; n_tv = 1;
        repeat (300) begin n_td = 16'($urandom); cyc(); end
        n_tv = 0; cyc();
        @(negedge clk);
        chk("drop_sat", drop_cnt, 255);
        n_full = 0; n_stop = 1; cyc(); cyc(); cyc(); cyc();

        // simultaneous starts ignored
        n_sf = 1; n_st = 1; cyc(); cyc();
        @(negedge clk);
        chk("t3_busy", busy, 0);
        chk("t3_f_en", f_en, 0);
        chk("t3_t_en", t_en, 0);

        // drain timeout
        n_sf = 1; cyc();
        n_fv = 1; n_fd = 16'($urandom); n_full = 1; cyc();
        n_fv = 0; n_stop = 1; n_empty = 0; cyc();
        drained = 0;
        for (int k = 1; k <= 2 * TO; k++) begin
            cyc();
            @(negedge clk);
            if (!busy) begin drained = k; break; end
        end
        chk("t5_drain_len", drained - 1, TO);
        chk("t5_timeout", timeout, 1);
        chk("t5_skid_lost", wr_en, 0);
        n_full = 0; n_empty = 1; cyc();
        n_st = 1; cyc(); cyc();
        @(negedge clk);
        chk("t5_cleared", timeout, 0);
        n_stop = 1; cyc(); cyc(); cyc();

        // parity and mid-run reset
        n_sf = 1; cyc();
        n_fv = 1; n_fd = 16'h00FF; cyc();
        n_fd = 16'h0001; cyc();
        @(negedge clk);
        chk("par_00ff", wr_parity, 0);
        n_fv = 0; cyc();
        @(negedge clk);
        chk("par_0001", wr_parity, 1);
        n_fv = 1; n_fd = 16'hBEEF; n_full = 1; cyc();
        n_rst = 1; cyc();
        n_fv = 0; n_full = 0; cyc();
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_f_en", f_en, 0);
        chk("mrst_modulo", modulo, 0);
        chk("mrst_wr_data", wr_data, 0);
        chk("mrst_word_cnt", word_cnt, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            n_sf = ($urandom_range(0, 9) == 0);
            n_st = ($urandom_range(0, 9) == 0);
            n_stop = ($urandom_range(0, 29) == 0);
            n_fv = 1'($urandom); n_fd = 16'($urandom);
            n_tv = 1'($urandom); n_td = 16'($urandom);
            n_full = ($urandom_range(0, 2) == 0);
            n_empty = ($urandom_range(0, 3) != 0);
            n_d2v = ($urandom_range(0, 4) == 0);
            n_rst = ($urandom_range(0, 999) == 0);
            cyc();
        end
        n_fv = 0; n_tv = 0; n_full = 0; n_empty = 1; n_d2v = 0;
        n_stop = 1; cyc();
        repeat (20) cyc();
        @(negedge clk);
        chk("end_idle", busy, 0);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
